mul_r4_seq: RTL and testbench

MUL_R4_SEQ -- requirements
Module: mul_r4_seq

---
 rtl/mul_r4_seq.sv | 108 ++++++++++
 tb/tb_mul_r4_seq.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mul_r4_seq.sv
// Sequential radix-4 Booth multiplier: one Booth digit per RUN cycle, valid/ready on both sides.
// Supports unsigned, signed and signed-by-unsigned products of two WIDTH-bit operands.
module mul_r4_seq #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic [1:0]           mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   p
);

   localparam int N  = WIDTH / 2 + 1;
   localparam int CW = $clog2(N);
   localparam int PW = 2 * WIDTH;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   step;
   logic [PW-1:0]   mcand;
   logic [PW-1:0]   acc;
   logic [PW-1:0]   pp;
   logic [PW-1:0]   acc_nxt;
   logic [WIDTH+1:0] mult;
   logic            prev;
   logic            zero_op;
   logic            last_step;
   logic            signed_a;
   logic            signed_b;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign signed_a  = (mode != 2'b00);
   assign signed_b  = mode[0];
   assign zero_op   = (a == '0) || (b == '0);
   assign last_step = (step == CW'(N - 1));
   assign acc_nxt   = acc + pp;

   // Arithmetic modulo 2^PW is enough: the truncated product only needs the low PW bits.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      pp = '0;
      unique case ({mult[1:0], prev})
         3'b001, 3'b010: pp = mcand;
         3'b011:         pp = mcand << 1;
         3'b100:         pp = -(mcand << 1);
         3'b101, 3'b110: pp = -mcand;
         default:        pp = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (in_valid)  state_nxt = zero_op ? DONE : RUN;
         RUN:     if (last_step) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // Multiplicand shifts left and multiplier right by one Booth digit each RUN cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand <= '0;
         mult  <= '0;
         prev  <= 1'b0;
         acc   <= '0;
         step  <= '0;
         p     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  mcand <= {{WIDTH{signed_a & a[WIDTH-1]}}, a};
                  mult  <= {{2{signed_b & b[WIDTH-1]}}, b};
                  prev  <= 1'b0;
                  acc   <= '0;
                  step  <= '0;
                  if (zero_op) p <= '0;
               end
            end
            RUN: begin
               acc   <= acc_nxt;
               mcand <= mcand << 2;
               mult  <= mult >> 2;
               prev  <= mult[1];
               step  <= step + CW'(1);
               if (last_step) p <= acc_nxt;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_r4_seq.sv
// Self-checking bench for mul_r4_seq (WIDTH=16): directed corner cases, reset, back-pressure
// and randomized operands against an arithmetic reference product.
module tb_mul_r4_seq;

   localparam int W = 16;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [W-1:0]    a;
   logic [W-1:0]    b;
   logic [1:0]      mode;
   logic            out_valid;
   logic            out_ready;
   logic [2*W-1:0]  p;

   int tests_run = 0;
   int tests_failed = 0;

   mul_r4_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p         (p)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Exact mathematical product, truncated to 2*W bits.
   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input logic [1:0] m);
      longint xv, yv;
      xv = (m != 2'b00) ? longint'($signed(x)) : longint'(x);
      yv = m[0] ? longint'($signed(y)) : longint'(y);
      return (2*W)'(xv * yv);
   endfunction

   // Called away from a clock edge. Returns after the product has been handed off.
   task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic [1:0] m,
                         input int hold, input string tag);
      logic [2*W-1:0] exp_p;
      int             lat;
      int             exp_lat;
      exp_p   = ref_mul(xa, xb, m);
      exp_lat = (xa == '0 || xb == '0) ? 0 : W / 2 + 1;
      check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      in_valid  = 1'b1;
      a         = xa;
      b         = xb;
      mode      = m;
      out_ready = (hold == 0);
      @(posedge clk);
      #1;
      // Operands and in_valid are ignored once accepted.
      in_valid = 1'b0;
      a        = W'($urandom);
      b        = W'($urandom);
      mode     = 2'($urandom);
      lat = 0;
      while (!out_valid && lat < 30) begin
         in_valid = 1'($urandom);
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      check({tag, "_p"}, 64'(p), 64'(exp_p));
      check({tag, "_busy_in_ready"}, 64'(in_ready), 64'd0);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         a        = W'($urandom);
         b        = W'($urandom);
         @(posedge clk);
         #1;
         check({tag, "_hold_p"}, 64'(p), 64'(exp_p));
         check({tag, "_hold_out_valid"}, 64'(out_valid), 64'd1);
         check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check({tag, "_release_in_ready"}, 64'(in_ready), 64'd1);
      check({tag, "_release_out_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_idle_p"}, 64'(p), 64'(exp_p));
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      logic [W-1:0] corners [4];
      corners[0] = 16'h0000;
      corners[1] = 16'h8000;
      corners[2] = 16'hFFFF;
      corners[3] = 16'h0001;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; mode = 2'b00;
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_p", 64'(p), 64'd0);

      // Release at a falling edge; the very next rising edge must accept.
      @(negedge clk);
      rst_n = 1'b1;
      run_op(16'd36, 16'd36, 2'b01, 0, "s36x36");
      run_op(16'hFFDC, 16'd36, 2'b01, 0, "sm36x36");
      check("ref_m36x36", 64'(ref_mul(16'hFFDC, 16'd36, 2'b01)), 64'hFFFFFAF0);
      run_op(16'hFFDC, 16'hFFDC, 2'b01, 1, "sm36xm36");
      check("ref_m36xm36", 64'(ref_mul(16'hFFDC, 16'hFFDC, 2'b01)), 64'h00000510);
      run_op(16'd0, 16'd36, 2'b01, 0, "zero_a");
      run_op(16'hFFFF, 16'hFFFF, 2'b00, 0, "uu_max");
      check("ref_uu_max", 64'(ref_mul(16'hFFFF, 16'hFFFF, 2'b00)), 64'hFFFE0001);
      run_op(16'hFFFF, 16'hFFFF, 2'b10, 0, "su_max");
      check("ref_su_max", 64'(ref_mul(16'hFFFF, 16'hFFFF, 2'b10)), 64'hFFFF0001);
      run_op(16'h8000, 16'h8000, 2'b01, 0, "ss_min");
      check("ref_ss_min", 64'(ref_mul(16'h8000, 16'h8000, 2'b01)), 64'h40000000);
      run_op(16'd36, 16'd36, 2'b01, 5, "backpressure");

      // Asynchronous reset at step 4 of RUN.
      in_valid = 1'b1; a = 16'd36; b = 16'd36; mode = 2'b01;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("midrun_rst_in_ready", 64'(in_ready), 64'd1);
      check("midrun_rst_out_valid", 64'(out_valid), 64'd0);
      check("midrun_rst_p", 64'(p), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(16'd36, 16'd36, 2'b01, 0, "post_rst");

      // Randomized operands across all modes, biased towards corner values.
      for (int i = 0; i < 60; i++) begin
         ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom);
         run_op(ra, rb, 2'($urandom), $urandom_range(0, 2), $sformatf("rnd%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
